// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register controller: per-register enable/flush and PC enable with
// post-reset bubble fill, multi-cycle load-use stall, mispredict flush and stats.
module pipe_hazard_ctrl #(
    parameter int NUM_REGS          = 4,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_DEPTH       = 2,
    parameter int INIT_CYCLES       = 2,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 mis_hit_i,
    input  logic                 load_use_i,
    input  logic                 regfile_wait_i,
    input  logic                 dmem_busy_i,
    input  logic                 cnt_clr_i,
    output logic                 pc_enable_o,
    output logic [NUM_REGS-1:0]  enable_o,
    output logic [NUM_REGS-1:0]  flush_no,
    output logic [1:0]           state_o,
    output logic [CNT_WIDTH-1:0] stall_cycles_o,
    output logic [CNT_WIDTH-1:0] flush_count_o
);

    typedef enum logic [1:0] {
        ST_INIT       = 2'd0,
        ST_RUN        = 2'd1,
        ST_LOAD_STALL = 2'd2
    } state_t;

    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam int SW = $clog2(LOAD_STALL_CYCLES + 1);
    localparam logic [IW-1:0] INIT_ONE  = IW'(1);
    localparam logic [SW-1:0] STALL_ONE = SW'(1);

    state_t                 r_state;
    logic [IW-1:0]          r_init_cnt;
    logic [SW-1:0]          r_stall_rem;
    logic [CNT_WIDTH-1:0]   r_stall_cnt;
    logic [CNT_WIDTH-1:0]   r_flush_cnt;

    logic w_freeze;
    logic w_mis;
    logic w_load;
    logic w_stall_inc;

    // Freeze outranks everything, and INIT masks both hazard inputs.
    assign w_freeze    = dmem_busy_i | regfile_wait_i;
    assign w_mis       = !w_freeze && (r_state != ST_INIT) && mis_hit_i;
    assign w_load      = !w_freeze && !w_mis &&
                         ((r_state == ST_RUN && load_use_i) || r_state == ST_LOAD_STALL);
    assign w_stall_inc = (r_state != ST_INIT) && (w_freeze || w_load);

    always_comb begin
        pc_enable_o = 1'b1;
        enable_o    = '1;
        flush_no    = '1;
        if (rst_i) begin
            pc_enable_o = 1'b0;
            enable_o    = '0;
            flush_no    = '0;
        end else if (w_freeze) begin
            pc_enable_o = 1'b0;
            enable_o    = '0;
        end else if (r_state == ST_INIT) begin
            pc_enable_o = 1'b0;
            flush_no    = '0;
        end else if (w_mis) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i < FLUSH_DEPTH) flush_no[i] = 1'b0;
            end
        end else if (w_load) begin
            // IF/ID holds the dependent instruction while a bubble enters ID/EX.
            pc_enable_o = 1'b0;
            enable_o[0] = 1'b0;
            flush_no[1] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= IW'(INIT_CYCLES);
            r_stall_rem <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_freeze) begin
                case (r_state)
                    ST_INIT: begin
                        if (r_init_cnt == INIT_ONE) r_state <= ST_RUN;
                        else r_init_cnt <= r_init_cnt - INIT_ONE;
                    end
                    ST_RUN: begin
                        if (w_load && LOAD_STALL_CYCLES > 1) begin
                            r_state     <= ST_LOAD_STALL;
                            r_stall_rem <= SW'(LOAD_STALL_CYCLES - 1);
                        end
                    end
                    ST_LOAD_STALL: begin
                        if (w_mis || r_stall_rem == STALL_ONE) begin
                            r_state     <= ST_RUN;
                            r_stall_rem <= '0;
                        end else begin
                            r_stall_rem <= r_stall_rem - STALL_ONE;
                        end
                    end
                    default: r_state <= ST_INIT;
                endcase
            end

            // Clear wins over a same-cycle increment; both counters saturate.
            if (cnt_clr_i) r_stall_cnt <= '0;
            else if (w_stall_inc && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;

            if (cnt_clr_i) r_flush_cnt <= '0;
            else if (w_mis && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign state_o        = r_state;
    assign stall_cycles_o = r_stall_cnt;
    assign flush_count_o  = r_flush_cnt;

endmodule
